clarvi_alu_sequencer: RTL and testbench
=======================================

CLARVI_ALU_SEQUENCER -- requirements
Module: clarvi_alu_sequencer

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16: width of the saturating stall-cycle counter.
REQ-002 SHALL have port clock, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start_valid, input, 1: upstream holds an instruction for issue.
REQ-005 SHALL have port start_ready, output, 1: sequencer accepts the instruction this cycle.
REQ-006 SHALL have port op, input, op_t: ALU operation, sampled on accept.
REQ-007 SHALL have port is32, input, 1: 32-bit (W) operation, sampled on accept.
REQ-008 SHALL have port stall, input, 1: pipeline stall; freezes sequencing.
REQ-009 SHALL have port part, output, 3: byte index driven to the ALU instr_part field.
REQ-010 SHALL have port part_valid, output, 1: part carries a live byte operation.
REQ-011 SHALL have port first, output, 1: current part is the first of the instruction.
REQ-012 SHALL have port last, output, 1: current part is the final one.
REQ-013 SHALL have port alu_stall, output, 1: drives the ALU stall input; equals stall OR NOT part_valid.
REQ-014 SHALL have port done, output, 1: one-cycle pulse in the cycle after the last part advances.
REQ-015 SHALL have port stall_cycles, output, STALL_CNT_W: count of stalled RUN cycles for the current/last instruction.

Function
REQ-016 SHALL implement an FSM with states IDLE and RUN plus a 3-bit step counter (0..7).
REQ-017 SHALL accept an instruction on a rising edge where start_valid AND start_ready; op and is32 latched; state goes to RUN, step=0.
REQ-018 SHALL assert start_ready in IDLE; in RUN, per REQ-032.
REQ-019 SHALL drive part from latched op/is32 and step; order by step 0..7: SLT, SLTU: 7,6,5,4,3,2,1,0.
REQ-020 SHALL use order SRL/SRA with is32=0: 7,6,5,4,3,2,1,0.
REQ-021 SHALL use order SRL/SRA with is32=1: 3,2,1,0,7,6,5,4.
REQ-022 SHALL use order 0,1,2,3,4,5,6,7 for all other ops, including SL, ADD, SUB with either is32.
REQ-023 SHALL assert part_valid only in RUN; first when step=0, last when step=7.
REQ-024 SHALL increment step on each edge in RUN with stall=0; stall=1 holds step, part, first, last.
REQ-025 SHALL move from RUN to IDLE on an edge where last=1 and stall=0, unless a new instruction is accepted that edge.
REQ-026 SHALL produce 8 part cycles per instruction with no stall; first part visible the cycle after accept.
REQ-027 SHALL ignore start_valid when start_ready=0; latched op/is32 unchanged mid-instruction.
REQ-028 SHALL drive part=0, first=0, last=0 in IDLE; stall in IDLE has no effect on state.
REQ-029 SHALL clear stall_cycles on accept, then increment once per RUN cycle with stall=1, saturating at all-ones; hold value in IDLE.

Reset
REQ-030 SHALL, on reset assertion (any time, including mid-instruction), immediately force IDLE, step=0, part=0, part_valid=0, first=0, last=0, done=0, stall_cycles=0, start_ready=1.
REQ-031 SHALL not accept an instruction on any edge while reset=1.

Configuration
REQ-032 SHALL, with CLARVI_SEQ_BACK2BACK_EN defined, also assert start_ready in RUN when last=1 and stall=0, so a new instruction's step 0 follows the previous step 7 with no bubble (done still pulses); without it, start_ready is 0 throughout RUN, leaving at least one IDLE cycle between instructions.

Verification
REQ-033 SHALL check: accept ADD, is32=0, no stall -> part 0..7 on 8 consecutive cycles, first on part 0, last on part 7, done next cycle.
REQ-034 SHALL check: accept SRA, is32=1 -> part sequence 3,2,1,0,7,6,5,4; accept SLTU -> 7,6,...,0.
REQ-035 SHALL check: stall=1 for 3 cycles at step 4 of SL -> part 4 held 4 cycles, alu_stall=1 while held, stall_cycles=3 at end.
REQ-036 SHALL check: reset pulsed at step 5 -> part_valid=0, part=0, start_ready=1 before next edge; following accept restarts at step 0.
REQ-037 SHALL check: start_valid held high over two ADDs -> with CLARVI_SEQ_BACK2BACK_EN, 16 consecutive part_valid cycles; without, one cycle of part_valid=0 between.
REQ-038 SHALL check: STALL_CNT_W=2, stall held 6 RUN cycles -> stall_cycles saturates at 3.

Source files
------------

// File: rtl/clarvi_alu_sequencer.sv
// Sequences an ALU instruction as 8 byte-wide parts (first part the cycle after accept; stall freezes it).
// start_ready is high in IDLE; with CLARVI_SEQ_BACK2BACK_EN it is also high on an unstalled last part.
module clarvi_alu_sequencer #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [3:0]             op,
  input  logic                   is32,
  input  logic                   stall,
  output logic [2:0]             part,
  output logic                   part_valid,
  output logic                   first,
  output logic                   last,
  output logic                   alu_stall,
  output logic                   done,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // op encoding shared with the ALU decoder
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             step_q, step_d;
  logic [3:0]             op_q, op_d;
  logic                   is32_q, is32_d;
  logic                   done_q, done_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic                   accept;
  logic                   is_shr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      step_q         <= 3'd0;
      op_q           <= 4'd0;
      is32_q         <= 1'b0;
      done_q         <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      op_q           <= op_d;
      is32_q         <= is32_d;
      done_q         <= done_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    part_valid = (state_q == RUN);
    first      = part_valid && (step_q == 3'd0);
    last       = part_valid && (step_q == 3'd7);
`ifdef CLARVI_SEQ_BACK2BACK_EN
    start_ready = (state_q == IDLE) || (last && !stall);
`else
    start_ready = (state_q == IDLE);
`endif
    accept    = start_valid && start_ready;
    alu_stall = stall || !part_valid;

    // Compares walk MSB byte down; W shifts walk the low word down before the high word.
    is_shr = (op_q == OP_SRL) || (op_q == OP_SRA);
    part   = 3'd0;
    if (part_valid) begin
      if ((op_q == OP_SLT) || (op_q == OP_SLTU) || (is_shr && !is32_q))
        part = ~step_q;
      else if (is_shr)
        part = {step_q[2], ~step_q[1:0]};
      else
        part = step_q;
    end

    state_d        = state_q;
    step_d         = step_q;
    op_d           = op_q;
    is32_d         = is32_q;
    done_d         = 1'b0;
    stall_cycles_d = stall_cycles_q;

    if (state_q == RUN && stall) begin
      if (stall_cycles_q != {STALL_CNT_W{1'b1}})
        stall_cycles_d = stall_cycles_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else if (state_q == RUN && !last) begin
      step_d = step_q + 3'd1;
    end else if (state_q == RUN) begin
      done_d  = 1'b1;
      state_d = IDLE;
      step_d  = 3'd0;
    end

    if (accept) begin
      state_d        = RUN;
      step_d         = 3'd0;
      op_d           = op;
      is32_d         = is32;
      stall_cycles_d = '0;
    end
  end

  assign done         = done_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_clarvi_alu_sequencer.sv
// Scoreboard bench for clarvi_alu_sequencer; a second instance with a 2-bit stall counter checks saturation.
module tb_clarvi_alu_sequencer;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SL   = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;

  typedef struct packed {
    logic [2:0] part;
    logic       first;
    logic       last;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic        is32 = 1'b0;
  logic        stall = 1'b0;
  logic        start_ready, part_valid, first, last, alu_stall, done;
  logic [2:0]  part;
  logic [15:0] stall_cycles;
  logic        start_ready2, part_valid2, first2, last2, alu_stall2, done2;
  logic [2:0]  part2;
  logic [1:0]  stall_cycles2;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  bit   mon_en   = 1'b0;
  bit   done_exp = 1'b0;

  always #5 clock = ~clock;

  clarvi_alu_sequencer dut (
    .clock(clock), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .is32(is32), .stall(stall), .part(part), .part_valid(part_valid),
    .first(first), .last(last), .alu_stall(alu_stall), .done(done), .stall_cycles(stall_cycles)
  );

  clarvi_alu_sequencer #(.STALL_CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .start_valid(start_valid), .start_ready(start_ready2),
    .op(op), .is32(is32), .stall(stall), .part(part2), .part_valid(part_valid2),
    .first(first2), .last(last2), .alu_stall(alu_stall2), .done(done2), .stall_cycles(stall_cycles2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_part(input logic [3:0] o, input logic w, input int s);
    int p;
    if (o == OP_SLT || o == OP_SLTU)       p = 7 - s;
    else if ((o == OP_SRL || o == OP_SRA) && !w) p = 7 - s;
    else if (o == OP_SRL || o == OP_SRA)   p = (s < 4) ? 3 - s : 11 - s;
    else                                   p = s;
    return p[2:0];
  endfunction

  task automatic push_instr(input logic [3:0] o, input logic w);
    exp_t e;
    for (int s = 0; s < 8; s++) begin
      e.part  = exp_part(o, w, s);
      e.first = (s == 0);
      e.last  = (s == 7);
      sb_q.push_back(e);
    end
  endtask

  // Returns at accept edge + 1, with part 0 visible and op/is32 scrambled.
  task automatic issue(input logic [3:0] o, input logic w);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    @(posedge clock); #1;
    start_valid = 1'b1; op = o; is32 = w;
    while (!acc && n < 20) begin
      @(negedge clock);
      acc = start_ready;
      @(posedge clock);
      n++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    else push_instr(o, w);
    #1;
    start_valid = 1'b0; op = 4'hF; is32 = ~w;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((part_valid || sb_q.size() != 0) && n < 40);
    if (n >= 40) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clock) begin
    exp_t e;
    bit   nxt;
    if (mon_en) begin
      nxt = 1'b0;
      chk("done", {31'd0, done}, {31'd0, done_exp});
      chk("alu_stall", {31'd0, alu_stall}, {31'd0, stall | ~part_valid});
      if (part_valid && !stall) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_part", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("part",  {29'd0, part},  {29'd0, e.part});
          chk("first", {31'd0, first}, {31'd0, e.first});
          chk("last",  {31'd0, last},  {31'd0, e.last});
          nxt = e.last;
        end
      end
      done_exp = nxt;
    end
  end

  logic [3:0] ops_tbl  [7] = '{OP_ADD, OP_SRA, OP_SLTU, OP_SUB, OP_SRL, OP_SLT, OP_XOR};
  logic       w_tbl    [7] = '{1'b0,   1'b1,   1'b0,    1'b1,   1'b0,   1'b1,   1'b1};

  initial begin
    int  gaps, seen, acc, n;
    bit  r, started;

    // Held in reset with a pending instruction: nothing may be accepted.
    start_valid = 1'b1; op = OP_ADD;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_part_valid",   {31'd0, part_valid},  32'd0);
    chk("rst_start_ready",  {31'd0, start_ready}, 32'd1);
    chk("rst_part",         {29'd0, part},        32'd0);
    chk("rst_first_last",   {30'd0, first, last}, 32'd0);
    chk("rst_done",         {31'd0, done},        32'd0);
    chk("rst_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    start_valid = 1'b0;
    reset = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) begin
      issue(ops_tbl[i], w_tbl[i]);
      wait_idle();
    end

    // Stall in IDLE changes nothing.
    stall = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_stall_pv", {31'd0, part_valid},  32'd0);
    chk("idle_stall_rdy", {31'd0, start_ready}, 32'd1);
    @(posedge clock); #1;
    stall = 1'b0;

    // Three stall cycles at step 4 of SL: part 4 held four cycles.
    issue(OP_SL, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("stall_hold_part", {29'd0, part}, 32'd4);
      chk("stall_alu_stall", {31'd0, alu_stall}, 32'd1);
      @(posedge clock);
    end
    #1;
    stall = 1'b0;
    @(negedge clock);
    chk("stall_release_part", {29'd0, part}, 32'd4);
    wait_idle();
    chk("stall_cycles_3", {16'd0, stall_cycles}, 32'd3);

    // Six stall cycles: 16-bit counter reads 6, 2-bit counter saturates at 3.
    issue(OP_ADD, 1'b0);
    stall = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("stall_cycles_6",   {16'd0, stall_cycles},  32'd6);
    chk("stall_cycles_sat", {30'd0, stall_cycles2}, 32'd3);
    stall = 1'b0;
    wait_idle();
    repeat (2) @(negedge clock);
    chk("stall_cycles_hold", {16'd0, stall_cycles}, 32'd6);

    // Reset pulsed with part 5 on the bus.
    issue(OP_ADD, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    chk("pre_reset_part", {29'd0, part}, 32'd5);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_part_valid",  {31'd0, part_valid},  32'd0);
    chk("mid_rst_part",        {29'd0, part},        32'd0);
    chk("mid_rst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("mid_rst_stall_cyc",   {16'd0, stall_cycles}, 32'd0);
    #1;
    reset = 1'b0;
    sb_q.delete();
    done_exp = 1'b0;
    mon_en = 1'b1;
    issue(OP_ADD, 1'b0);
    wait_idle();

    // Two ADDs with start_valid held high.
    @(posedge clock); #1;
    start_valid = 1'b1; op = OP_ADD; is32 = 1'b0;
    gaps = 0; seen = 0; acc = 0; n = 0; started = 1'b0;
    while (seen < 16 && n < 60) begin
      @(negedge clock);
      r = start_valid && start_ready;
      if (part_valid) begin
        seen++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      @(posedge clock);
      n++;
      if (r) begin
        push_instr(OP_ADD, 1'b0);
        acc++;
        if (acc == 2) begin
          #1;
          start_valid = 1'b0; op = 4'hF;
        end
      end
    end
    chk("b2b_seen", seen, 32'd16);
`ifdef CLARVI_SEQ_BACK2BACK_EN
    chk("b2b_gaps", gaps, 32'd0);
`else
    chk("b2b_gaps", gaps, 32'd1);
`endif
    wait_idle();
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
